// File: rtl/nco_pkg.sv
// Shared constants for the NCO sweep controller: default widths, sweep modes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nco_pkg;

  localparam int FTW_W_DEF   = 32;
  localparam int DWELL_W_DEF = 16;

  // Sweep mode encodings as seen on cfg_mode
  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_SAW  = 2'b11;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DWELL = 2'd1;
  localparam state_t ST_STEP  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Single-shot modes (up/down) end with a done pulse; mode[1] marks the repeating ones.
  function automatic logic is_single(input logic [1:0] mode);
    return !mode[1];
  endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell down-counter: load a count, decrement towards zero, flag zero.
// Latency: load/decrement visible the cycle after the request; zero_o is combinational from the count.
// Backpressure: none; the counter saturates at zero and never wraps.
// Ports: clk, reset (sync, active-high), load_i/load_val_i (load, wins over dec),
//        dec_i (decrement when nonzero), zero_o (count == 0).
module nco_dwell_timer
  import nco_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep scheduler driving the phase accumulator tuning word from start to stop FTW.
// Latency: first FTW and phase_clr appear the cycle after descriptor accept; each FTW held max(dwell,1) cycles.
// Backpressure: cfg_ready is high only in IDLE; a descriptor offered while sweeping waits at the source.
// Ports: clk, reset (sync, active-high); cfg_valid/cfg_ready handshake with cfg_start/stop/step/dwell/mode;
//        abort (return to IDLE, hold FTW); ftw_out (registered tuning word), phase_clr (1-cycle pulse),
//        busy (DWELL/STEP), done (1-cycle pulse at end of a single sweep).
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int FTW_W   = FTW_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FTW_W-1:0]   cfg_start,
  input  logic [FTW_W-1:0]   cfg_stop,
  input  logic [FTW_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               abort,
  output logic [FTW_W-1:0]   ftw_out,
  output logic               phase_clr,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [FTW_W-1:0]   ftw_q, ftw_d;
  logic [FTW_W-1:0]   start_q, start_d;
  logic [FTW_W-1:0]   stop_q, stop_d;
  logic [FTW_W-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         mode_q, mode_d;
  logic               down_q, down_d;
  logic               pclr_q, pclr_d;

  logic               hold_end;
  logic               reached;
  logic               turn;
  logic               eff_down;
  logic [FTW_W-1:0]   eff_stop;
  logic [FTW_W-1:0]   next_ftw;
  logic [FTW_W:0]     sum;
  logic [FTW_W:0]     diff;
  logic [DWELL_W-1:0] cfg_dwell_eff;

  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;

  nco_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign cfg_dwell_eff = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;

  // Last cycle of the current FTW's hold. STEP itself is the first held cycle of
  // a new FTW, so with a dwell of 1 the hold ends in STEP and STEP repeats.
  assign hold_end = ((state_q == ST_DWELL) && tmr_zero) ||
                    ((state_q == ST_STEP) && (dwell_q == DWELL_W'(1)));

  // Endpoint test uses the FTW currently on the output; a zero step never moves,
  // so it counts as having arrived after the first dwell.
  assign reached  = (ftw_q == stop_q) || (step_q == '0);

  // A triangle turnaround swaps direction and endpoint in the same cycle as the
  // step, so the endpoint value is held only once per pass.
  assign turn     = reached && (mode_q == MODE_TRI);
  assign eff_down = down_q ^ turn;
  assign eff_stop = turn ? start_q : stop_q;

  // One extra bit catches carry (up) and borrow (down); either clamps to the endpoint.
  assign sum  = {1'b0, ftw_q} + {1'b0, step_q};
  assign diff = {1'b0, ftw_q} - {1'b0, step_q};

  always_comb begin
    next_ftw = eff_stop;
    if (eff_down) begin
      if (!diff[FTW_W] && (diff[FTW_W-1:0] > eff_stop)) begin
        next_ftw = diff[FTW_W-1:0];
      end
    end else begin
      if (!sum[FTW_W] && (sum[FTW_W-1:0] < eff_stop)) begin
        next_ftw = sum[FTW_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ftw_d    = ftw_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    mode_d   = mode_q;
    down_d   = down_q;
    pclr_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = dwell_q - DWELL_W'(2);
    tmr_dec  = (state_q == ST_DWELL);

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          start_d  = cfg_start;
          stop_d   = cfg_stop;
          step_d   = cfg_step;
          dwell_d  = cfg_dwell_eff;
          mode_d   = cfg_mode;
          // Repeating modes head from start toward stop, whichever way that is.
          down_d   = (cfg_mode == MODE_DOWN) || (cfg_mode[1] && (cfg_stop < cfg_start));
          ftw_d    = cfg_start;
          pclr_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = cfg_dwell_eff - DWELL_W'(1);
          state_d  = ST_DWELL;
        end
      end

      ST_DWELL, ST_STEP: begin
        if (hold_end) begin
          if (reached && is_single(mode_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STEP;
            if (reached && (mode_q == MODE_SAW)) begin
              ftw_d = start_q;
            end else begin
              ftw_d = next_ftw;
            end
            if (turn) begin
              start_d = stop_q;
              stop_d  = start_q;
              down_d  = ~down_q;
            end
          end
        end else if (state_q == ST_STEP) begin
          // STEP already used one held cycle; DWELL covers the remaining dwell-1.
          tmr_load = 1'b1;
          state_d  = ST_DWELL;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      ftw_d   = ftw_q;
      pclr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ftw_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_UP;
      down_q  <= 1'b0;
      pclr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ftw_q   <= ftw_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      down_q  <= down_d;
      pclr_q  <= pclr_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_DWELL) || (state_q == ST_STEP);
  assign done      = (state_q == ST_DONE);
  assign phase_clr = pclr_q;
  assign ftw_out   = ftw_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: expected per-cycle outputs are queued at issue time,
// a negedge monitor pops and compares whenever the DUT is busy or pulsing done.
// Reference model works on plain integers: hold each FTW for the dwell, then step/clamp/turn.
module tb_nco_sweep_ctrl;
  import nco_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start, cfg_stop, cfg_step;
  logic [15:0] cfg_dwell;
  logic [1:0]  cfg_mode;
  logic        abort;
  logic [31:0] ftw_out;
  logic        phase_clr, busy, done;

  typedef struct {
    logic [31:0] ftw;
    bit          pclr;
    bit          done;
  } ent_t;

  ent_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  nco_sweep_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_dwell (cfg_dwell),
    .cfg_mode  (cfg_mode),
    .abort     (abort),
    .ftw_out   (ftw_out),
    .phase_clr (phase_clr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expand the sweep into one entry per output cycle, up to lim entries.
  task automatic build(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                       input int dw, input logic [1:0] m, input int lim,
                       output logic [31:0] last, output bit fin);
    longint cur, a, b, stp, t;
    bit     up;
    int     d, n;
    ent_t   en;
    cur = s; a = s; b = e; stp = st;
    d = (dw == 0) ? 1 : dw;
    n = 0; fin = 0; last = s;
    up = (m == MODE_UP) || (m[1] && (e >= s));
    forever begin
      for (int i = 0; i < d; i++) begin
        en.ftw = cur[31:0]; en.pclr = (n == 0); en.done = 0;
        exp_q.push_back(en);
        n++;
        last = cur[31:0];
        if (n >= lim) return;
      end
      if (cur == b || stp == 0) begin
        if (!m[1]) begin
          en.ftw = cur[31:0]; en.pclr = 0; en.done = 1;
          exp_q.push_back(en);
          fin = 1;
          return;
        end
        if (m == MODE_SAW) begin
          cur = a;
          continue;
        end
        t = a; a = b; b = t; up = !up;
      end
      if (up) cur = (cur + stp >= b) ? b : cur + stp;
      else    cur = (cur - stp <= b) ? b : cur - stp;
    end
  endtask

  // Monitor: every cycle the DUT presents output, pop one expected entry.
  always @(negedge clk) begin
    if (!reset && (busy || done)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: ftw %0h busy %0b done %0b, expected no activity",
                 ftw_out, busy, done);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        check("mon_ftw",  ftw_out,   e.ftw);
        check("mon_pclr", phase_clr, e.pclr);
        check("mon_done", done,      e.done);
        check("mon_busy", busy,      !e.done);
      end
    end
  end

  task automatic issue(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                       input logic [15:0] dw, input logic [1:0] m, output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!cfg_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cfg_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: cfg_ready %0b, expected 1", cfg_ready);
      ok = 0;
      return;
    end
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = m;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    ok = 1;
  endtask

  task automatic run_sweep(input string tag, input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] st, input int dw, input logic [1:0] m,
                           input int lim);
    logic [31:0] last;
    bit          fin, ok;
    int          w;
    build(s, e, st, dw, m, lim, last, fin);
    issue(s, e, st, dw[15:0], m, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    // Offer a different descriptor while busy; it must not be taken, and the
    // latched configuration must not follow the inputs.
    cfg_valid = 1'b1;
    cfg_start = $urandom; cfg_stop = $urandom; cfg_step = $urandom;
    cfg_dwell = 16'($urandom); cfg_mode = 2'($urandom);
    if (!fin && lim == 1) abort = 1'b1;
    @(negedge clk);
    check({tag, "_ready_busy"}, cfg_ready, 1'b0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    if (!fin && lim >= 2) begin
      repeat (lim - 2) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
    w = 0;
    while (exp_q.size() != 0 && w < lim + 50) begin
      @(posedge clk);
      w++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check({tag, "_idle_ready"}, cfg_ready, 1'b1);
    check({tag, "_idle_busy"},  busy,      1'b0);
    check({tag, "_idle_done"},  done,      1'b0);
    check({tag, "_idle_ftw"},   ftw_out,   last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] base, s, e, st, last;
    bit          fin, ok;
    int          dw, lim;
    logic [1:0]  m;

    reset = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ftw",   ftw_out,   32'd0);
    check("rst_busy",  busy,      1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_pclr",  phase_clr, 1'b0);
    check("rst_done",  done,      1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed sweeps
    run_sweep("up", 32'd100, 32'd130, 32'd10, 4, MODE_UP, 1000);
    check("up_final", ftw_out, 32'd130);
    run_sweep("clamp", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, MODE_UP, 1000);
    check("clamp_final", ftw_out, 32'hFFFF_FFFF);
    run_sweep("tri", 32'd10, 32'd30, 32'd10, 2, MODE_TRI, 13);
    check("tri_abort_ftw", ftw_out, 32'd30);
    run_sweep("saw", 32'd5, 32'd7, 32'd1, 1, MODE_SAW, 9);
    check("saw_abort_ftw", ftw_out, 32'd7);
    run_sweep("step0", 32'd50, 32'd20, 32'd0, 3, MODE_DOWN, 1000);
    check("step0_final", ftw_out, 32'd50);
    run_sweep("dwell0", 32'd7, 32'd9, 32'd1, 0, MODE_UP, 100);
    run_sweep("down", 32'd100, 32'd3, 32'd25, 2, MODE_DOWN, 100);

    // Reset in the middle of a dwell
    build(32'd1000, 32'd2000, 32'd100, 5, MODE_UP, 1000, last, fin);
    issue(32'd1000, 32'd2000, 32'd100, 16'd5, MODE_UP, ok);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ftw",   ftw_out,   32'd0);
    check("mid_rst_busy",  busy,      1'b0);
    check("mid_rst_ready", cfg_ready, 1'b1);
    check("mid_rst_pclr",  phase_clr, 1'b0);
    check("mid_rst_done",  done,      1'b0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized sweeps
    for (int k = 0; k < 40; k++) begin
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0;
      s    = base + 32'($urandom_range(0, 255));
      e    = ($urandom_range(0, 7) == 0) ? s : base + 32'($urandom_range(0, 255));
      st   = ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
      dw   = $urandom_range(0, 4);
      m    = 2'($urandom_range(0, 3));
      lim  = $urandom_range(1, 60);
      run_sweep("rnd", s, e, st, dw, m, lim);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
